tdt_dtm_apb_master: RTL
=======================

// Module: tdt_dtm_apb_master
// PURPOSE
//  DMI responder end of the DTM request interface (wr_vld/addr/flg/wdata -> ready/rdata).
//  Turns each single-cycle DTM request into one APB3 transfer toward the debug module, in the tclk domain.
//  Returns a one-cycle ready pulse carrying read data.
//  Sits between the DTM instruction/data-register block and the debug-module APB slave port.
// PARAMETERS
//  DTM_ABITS    16   DMI word-address width.
//  TIMEOUT_W    8    Timeout counter width.
//  TIMEOUT_CYC  200  ACCESS cycles without pready before forced completion. Must be < 2**TIMEOUT_W.
// PORTS
//  tclk               in   1          Clock.
//  trst_b             in   1          Asynchronous active-low reset.
//  dtm_apbm_wr_vld    in   1          Request pulse; one cycle.
//  dtm_apbm_wr_addr   in   DTM_ABITS  DMI word address.
//  dtm_apbm_wr_flg    in   2          Op: 01 = read, 10 = write; 00/11 are ignored.
//  dtm_apbm_wdata     in   32         Write data.
//  dtm_apbm_abort     in   1          Hard-reset pulse from the DTM (dmihardreset).
//  dtm_apbm_err_clr   in   1          Clears the sticky error (dmireset).
//  apbm_dtm_wr_ready  out  1          Completion pulse; one cycle.
//  apbm_dtm_rdata     out  32         Response data; held until the next completion.
//  apbm_dtm_err       out  1          Sticky error: pslverr, timeout or dropped request.
//  apbm_psel          out  1          APB select.
//  apbm_penable       out  1          APB enable.
//  apbm_pwrite        out  1          APB direction: 1 = write.
//  apbm_paddr         out  DTM_ABITS+2  APB byte address = {wr_addr, 2'b00}.
//  apbm_pwdata        out  32         APB write data.
//  apbm_prdata        in   32         APB read data.
//  apbm_pready        in   1          APB ready.
//  apbm_pslverr       in   1          APB slave error.
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE.
//  FSM states (encoded in tdt_dtm_cfg.vh):
//   - IDLE: on wr_vld with flg==01 or flg==10, latch addr/flg/wdata and go to SETUP.
//     Other flg values are ignored: no transfer, no ready.
//   - SETUP: psel=1, penable=0 for exactly 1 cycle, then go to ACCESS.
//   - ACCESS: psel=1, penable=1. paddr/pwrite/pwdata are stable from SETUP through ACCESS.
//     On pready, go to RESP.
//   - RESP: wr_ready=1 for 1 cycle, then go to IDLE. psel=penable=0.
//  Latency: wr_vld in cycle N -> psel N+1 -> penable N+2; pready in N+k -> wr_ready in N+k+1.
//   Minimum request-to-ready latency is 3 cycles.
//  Read data:
//   - Read, pready & !pslverr: rdata <= prdata.
//   - Read, pready & pslverr: rdata <= 0 and err <= 1.
//   - Write: rdata <= 0. A write with pslverr also sets err.
//  wr_vld while not IDLE: request dropped, err <= 1, current transfer unaffected.
//  abort:
//   - In SETUP/ACCESS: the APB transfer runs to pready (protocol-legal), the RESP pulse is suppressed, FSM returns to IDLE.
//   - In RESP: the ready pulse is suppressed.
//   - In any state: err cleared.
//  err_clr: clears err. If err_clr and a new error event occur in the same cycle, the error event wins.
//  Same-cycle wr_vld and abort in IDLE: abort wins, request discarded.
//  Reset mid-transfer: asynchronous return to IDLE with psel=0 (APB slave shares trst_b).
// CONFIGURATION
//  TDT_DTM_APBM_TIMEOUT_EN defined:
//   - Counter clears on ACCESS entry and increments each ACCESS cycle without pready.
//   - At count == TIMEOUT_CYC-1: drop psel/penable, rdata <= 32'hFFFF_FFFF, err <= 1, go to RESP (ready pulse issued).
//   - pready arriving in the same cycle as expiry counts as a normal completion.
//  Not defined: no counter logic; ACCESS waits indefinitely for pready.
// STRUCTURE
//  tdt_dtm_cfg.vh: FSM state encodings (IDLE/SETUP/ACCESS/RESP), op codes OP_RD=2'b01 / OP_WR=2'b10,
//   timeout fill value 32'hFFFF_FFFF.
//  Sub-module tdt_dtm_apbm_tocnt (counter + expiry compare), instantiated only under TDT_DTM_APBM_TIMEOUT_EN.
// TESTING
//  1. Read addr=16'h0011, pready=1 first ACCESS cycle, prdata=32'h1234_5678
//     -> paddr=18'h00044, pwrite=0, ready 3 cycles after wr_vld, rdata=32'h1234_5678, err=0.
//  2. Write addr=16'h0010, wdata=32'h8000_0001, pready after 4 wait cycles
//     -> pwdata stable through all ACCESS cycles, pwrite=1, one ready pulse, rdata=0.
//  3. Read with pslverr=1 at pready -> rdata=0, err=1; err_clr pulse -> err=0.
//  4. Second wr_vld while in ACCESS -> single APB transfer only, err=1, exactly one ready pulse.
//  5. abort during ACCESS, pready two cycles later -> transfer completes on bus, no ready, err=0, FSM back in IDLE.
//  6. TIMEOUT_EN, TIMEOUT_CYC=8, pready held 0 -> psel drops after 8 ACCESS cycles,
//     rdata=32'hFFFF_FFFF, ready pulse, err=1. Without the macro, the bus stays in ACCESS indefinitely.

Source files
------------

// File: rtl/tdt_dtm_apb_master_pkg.sv
//------------------------------------------------------------------------------
// Module  : tdt_dtm_apb_master_pkg
// Brief   : FSM state encodings, DMI op codes and timeout fill value for the
//           DTM-to-APB master.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tdt_dtm_apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } apbm_state_t;

  localparam logic [1:0]  OP_RD        = 2'b01;
  localparam logic [1:0]  OP_WR        = 2'b10;
  localparam logic [31:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

  function automatic logic op_valid(input logic [1:0] flg);
    return (flg == OP_RD) || (flg == OP_WR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdt_dtm_apb_master_if.sv
//------------------------------------------------------------------------------
// Module  : tdt_dtm_req_if / tdt_apb_if
// Brief   : DTM request/response interface and APB3 bus interface.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tdt_dtm_req_if #(
  parameter int DTM_ABITS = 16
);
  logic                 dtm_apbm_wr_vld;
  logic [DTM_ABITS-1:0] dtm_apbm_wr_addr;
  logic [1:0]           dtm_apbm_wr_flg;
  logic [31:0]          dtm_apbm_wdata;
  logic                 dtm_apbm_abort;
  logic                 dtm_apbm_err_clr;
  logic                 apbm_dtm_wr_ready;
  logic [31:0]          apbm_dtm_rdata;
  logic                 apbm_dtm_err;

  modport master (
    output dtm_apbm_wr_vld, dtm_apbm_wr_addr, dtm_apbm_wr_flg, dtm_apbm_wdata,
           dtm_apbm_abort, dtm_apbm_err_clr,
    input  apbm_dtm_wr_ready, apbm_dtm_rdata, apbm_dtm_err
  );

  modport slave (
    input  dtm_apbm_wr_vld, dtm_apbm_wr_addr, dtm_apbm_wr_flg, dtm_apbm_wdata,
           dtm_apbm_abort, dtm_apbm_err_clr,
    output apbm_dtm_wr_ready, apbm_dtm_rdata, apbm_dtm_err
  );
endinterface

interface tdt_apb_if #(
  parameter int ADDR_W = 18
);
  logic              apbm_psel;
  logic              apbm_penable;
  logic              apbm_pwrite;
  logic [ADDR_W-1:0] apbm_paddr;
  logic [31:0]       apbm_pwdata;
  logic [31:0]       apbm_prdata;
  logic              apbm_pready;
  logic              apbm_pslverr;

  modport master (
    output apbm_psel, apbm_penable, apbm_pwrite, apbm_paddr, apbm_pwdata,
    input  apbm_prdata, apbm_pready, apbm_pslverr
  );

  modport slave (
    input  apbm_psel, apbm_penable, apbm_pwrite, apbm_paddr, apbm_pwdata,
    output apbm_prdata, apbm_pready, apbm_pslverr
  );
endinterface

`default_nettype wire

// File: rtl/tdt_dtm_apbm_tocnt.sv
//------------------------------------------------------------------------------
// Module  : tdt_dtm_apbm_tocnt
// Brief   : ACCESS-phase wait counter with expiry compare; only instantiated
//           when TDT_DTM_APBM_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tdt_dtm_apbm_tocnt #(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_CYC = 200
) (
  input  wire logic tclk,
  input  wire logic trst_b,
  input  wire logic i_clr,
  input  wire logic i_inc,
  output logic      o_expire
);

  localparam logic [TIMEOUT_W-1:0] C_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [TIMEOUT_W-1:0] r_cnt;

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + TIMEOUT_W'(1);
    end
  end

  assign o_expire = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/tdt_dtm_apb_master.sv
//------------------------------------------------------------------------------
// Module  : tdt_dtm_apb_master
// Brief   : Turns single-cycle DTM DMI requests into APB3 transfers and returns
//           a one-cycle ready pulse with read data. Optional ACCESS timeout
//           enabled by defining TDT_DTM_APBM_TIMEOUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tdt_dtm_apb_master
  import tdt_dtm_apb_master_pkg::*;
#(
  parameter int DTM_ABITS   = 16,
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_CYC = 200
) (
  input  wire logic  tclk,
  input  wire logic  trst_b,
  tdt_dtm_req_if.slave dtm,
  tdt_apb_if.master    apb
);

  apbm_state_t          r_state;
  logic [DTM_ABITS-1:0] r_addr;
  logic                 r_write;
  logic [31:0]          r_wdata;
  logic                 r_psel;
  logic                 r_penable;
  logic                 r_ready;
  logic                 r_err;
  logic                 r_abort_pend;
  logic [31:0]          r_rdata;

  logic w_req_ok;
  logic w_in_access;
  logic w_abort_now;
  logic w_done;
  logic w_timeout;
  logic w_err_set;

  // Abort in the same cycle as a request in IDLE discards the request.
  assign w_req_ok    = dtm.dtm_apbm_wr_vld && op_valid(dtm.dtm_apbm_wr_flg)
                       && !dtm.dtm_apbm_abort;
  assign w_in_access = (r_state == ST_ACCESS);
  assign w_abort_now = r_abort_pend || dtm.dtm_apbm_abort;
  assign w_done      = w_in_access && (apb.apbm_pready || w_timeout);

  // pready on the expiry cycle is a normal completion, so pslverr decides then.
  assign w_err_set = (dtm.dtm_apbm_wr_vld && (r_state != ST_IDLE))
                   || (w_done && !w_abort_now
                       && (apb.apbm_pready ? apb.apbm_pslverr : 1'b1));

`ifdef TDT_DTM_APBM_TIMEOUT_EN
  tdt_dtm_apbm_tocnt #(
    .TIMEOUT_W   (TIMEOUT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tocnt (
    .tclk     (tclk),
    .trst_b   (trst_b),
    .i_clr    (r_state == ST_SETUP),
    .i_inc    (w_in_access && !apb.apbm_pready),
    .o_expire (w_timeout)
  );
`else
  logic w_unused_cfg;
  assign w_timeout    = 1'b0;
  assign w_unused_cfg = TIMEOUT_W[0] ^ TIMEOUT_CYC[0];
`endif

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_ready      <= 1'b0;
      r_err        <= 1'b0;
      r_abort_pend <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_ok) begin
            r_addr  <= dtm.dtm_apbm_wr_addr;
            r_write <= (dtm.dtm_apbm_wr_flg == OP_WR);
            r_wdata <= dtm.dtm_apbm_wdata;
            r_psel  <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable    <= 1'b1;
          r_abort_pend <= dtm.dtm_apbm_abort;
          r_state      <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_done) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_abort_pend <= 1'b0;
            if (w_abort_now) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_RESP;
              r_ready <= 1'b1;
              if (!apb.apbm_pready)
                r_rdata <= TIMEOUT_FILL;
              else if (r_write || apb.apbm_pslverr)
                r_rdata <= '0;
              else
                r_rdata <= apb.apbm_prdata;
            end
          end else if (dtm.dtm_apbm_abort) begin
            r_abort_pend <= 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_err_set)
        r_err <= 1'b1;
      else if (dtm.dtm_apbm_abort || dtm.dtm_apbm_err_clr)
        r_err <= 1'b0;
    end
  end

  // An abort landing on the RESP cycle still has to swallow the pulse.
  assign dtm.apbm_dtm_wr_ready = r_ready && !dtm.dtm_apbm_abort;
  assign dtm.apbm_dtm_rdata    = r_rdata;
  assign dtm.apbm_dtm_err      = r_err;

  assign apb.apbm_psel    = r_psel;
  assign apb.apbm_penable = r_penable;
  assign apb.apbm_pwrite  = r_write;
  assign apb.apbm_paddr   = {r_addr, 2'b00};
  assign apb.apbm_pwdata  = r_wdata;

endmodule

`default_nettype wire
